// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto single-port memory with starvation guard.
// Define MEM_ARB_RMW_EN to honour d_be via read-modify-write partial stores.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [`ADDR-1:0]  i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [`WORD-1:0]  i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [`ADDR-1:0]  d_addr,
    input  logic [`WORD-1:0]  d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [`WORD-1:0]  d_rdata,
    output logic [`ADDR-1:0]  mem_a,
    output logic              mem_w,
    output logic [`WORD-1:0]  mem_d,
    input  logic [`WORD-1:0]  mem_q
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {ACCEPT, RMW_WR} state_t;
    state_t state, state_nx;
    logic [CW-1:0] starve_cnt;
    logic rt_i, rt_d, rt_st, partial;
    logic [`ADDR-1:0] rmw_a;
    logic [`WORD-1:0] merged;
`ifdef MEM_ARB_RMW_EN
    logic [`WORD-1:0] rmw_wd;
    logic [3:0] rmw_be;
    always_comb begin
        merged = mem_q;
        for (int b = 0; b < 4; b++)
            if (rmw_be[b]) merged[8*b +: 8] = rmw_wd[8*b +: 8];
    end
    always_ff @(posedge clk)
        if (partial) begin
            rmw_a  <= d_addr;
            rmw_wd <= d_wdata;
            rmw_be <= d_be;
        end
    assign partial = d_gnt && d_we && d_be != 4'hF;
`else
    logic unused_be;
    assign unused_be = ^d_be;
    assign rmw_a = '0;
    assign merged = '0;
    assign partial = 1'b0;
`endif
    always_comb begin
        state_nx = ACCEPT;
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        mem_a = '0;
        mem_w = 1'b0;
        mem_d = '0;
        if (!rst && state == RMW_WR) begin
            mem_a = rmw_a;
            mem_w = 1'b1;
            mem_d = merged;
        end else if (!rst) begin
            i_gnt = i_req && (!d_req || starve_cnt == CW'(STARVE_LIMIT));
            d_gnt = d_req && !i_gnt;
            state_nx = partial ? RMW_WR : ACCEPT;
            mem_a = i_gnt ? i_addr : d_gnt ? d_addr : '0;
            mem_w = d_gnt && d_we && !partial;
            mem_d = mem_w ? d_wdata : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
            starve_cnt <= '0;
            rt_i <= 1'b0;
            rt_d <= 1'b0;
            rt_st <= 1'b0;
        end else begin
            state <= state_nx;
            starve_cnt <= (!i_req || i_gnt) ? '0 :
                          (d_gnt && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
            rt_i <= i_gnt;
            rt_d <= (d_gnt && !partial) || state == RMW_WR;
            rt_st <= (d_gnt && d_we) || state == RMW_WR;
        end
    end
    // the tag drives responses one cycle after the grant, aligned with mem_q
    assign i_rvalid = rt_i && !rst;
    assign i_rdata  = i_rvalid ? mem_q : '0;
    assign d_rvalid = rt_d && !rst;
    assign d_rdata  = (d_rvalid && !rt_st) ? mem_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a memory model and a shadow reference.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module tb_mem_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic i_req = 0, i_gnt, i_rvalid;
    logic [`ADDR-1:0] i_addr = '0;
    logic [`WORD-1:0] i_rdata;
    logic d_req = 0, d_we = 0, d_gnt, d_rvalid;
    logic [`ADDR-1:0] d_addr = '0;
    logic [`WORD-1:0] d_wdata = '0, d_rdata;
    logic [3:0] d_be = 4'hF;
    logic [`ADDR-1:0] mem_a;
    logic mem_w;
    logic [`WORD-1:0] mem_d, mem_q = '0;
    logic [`WORD-1:0] mem [0:65535];
    logic pl_en = 0;
    logic [`ADDR-1:0] pl_a = '0;
    logic [`WORD-1:0] pl_d = '0;
    int n_chk = 0, n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_w) mem[mem_a] <= mem_d;
        mem_q <= mem[mem_a];
    end

    task automatic preload(input logic [`ADDR-1:0] a, input logic [`WORD-1:0] d);
        pl_en = 1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1; i_req = 1; d_req = 1; d_we = 1; i_addr = 16'h5; d_addr = 16'h7; d_wdata = 32'hFFFF_FFFF;
        step(); step();
        @(negedge clk);
        n_chk++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_w} !== 5'b0 || i_rdata !== '0 || d_rdata !== '0 ||
            mem_a !== '0 || mem_d !== '0) begin
            n_fail++;
            $display("FAIL reset: gnt=%b%b rv=%b%b mem_w=%b mem_a=%h mem_d=%h ir=%h dr=%h, want all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, mem_w, mem_a, mem_d, i_rdata, d_rdata);
        end
        i_req = 0; d_req = 0; d_we = 0;
        @(posedge clk); #1;
        rst = 0;
        step();
    endtask

    task automatic test_fetch;
        preload(16'h0010, 32'hDEADBEEF);
        i_req = 1; i_addr = 16'h0010;
        @(negedge clk);
        n_chk++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_a !== 16'h0010 || mem_w !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_grant: i_gnt=%b d_gnt=%b mem_a=%h mem_w=%b, want 1 0 0010 0", i_gnt, d_gnt, mem_a, mem_w);
        end
        step(); i_req = 0;
        @(negedge clk);
        n_chk++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_data: i_rvalid=%b i_rdata=%h, want 1 deadbeef", i_rvalid, i_rdata);
        end
        step();
    endtask

    task automatic test_starve;
        int run = 0;
        logic want_i;
        i_req = 1; d_req = 1; d_we = 0; i_addr = 16'h3; d_addr = 16'h4;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            want_i = (k % 5) == 4;
            n_chk++;
            if (i_gnt !== want_i || d_gnt !== !want_i) begin
                n_fail++;
                $display("FAIL starve_pattern[%0d]: i_gnt=%b d_gnt=%b, want %b %b", k, i_gnt, d_gnt, want_i, !want_i);
            end
            run = i_gnt ? 0 : run + 1;
            n_chk++;
            if (run > 4) begin
                n_fail++;
                $display("FAIL starve_run: %0d cycles without i_gnt, want at most 4", run);
            end
            step();
        end
        i_req = 0; d_req = 0;
        step();
    endtask

    task automatic test_store_load;
        d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 32'h12345678; d_be = 4'hF;
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1 || mem_w !== 1'b1 || mem_a !== 16'h0100 || mem_d !== 32'h12345678) begin
            n_fail++;
            $display("FAIL store_issue: d_gnt=%b mem_w=%b mem_a=%h mem_d=%h, want 1 1 0100 12345678", d_gnt, mem_w, mem_a, mem_d);
        end
        step(); d_we = 0;
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1 || mem_w !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL store_ack: d_gnt=%b mem_w=%b d_rvalid=%b d_rdata=%h, want 1 0 1 0", d_gnt, mem_w, d_rvalid, d_rdata);
        end
        step(); d_req = 0;
        @(negedge clk);
        n_chk++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_after_store: d_rvalid=%b d_rdata=%h, want 1 12345678", d_rvalid, d_rdata);
        end
        step();
    endtask

    task automatic test_partial;
        preload(16'h0020, 32'hAABBCCDD);
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h11223344; d_be = 4'b0101;
        @(negedge clk);
`ifdef MEM_ARB_RMW_EN
        n_chk++;
        if (d_gnt !== 1'b1 || mem_w !== 1'b0 || mem_a !== 16'h0020) begin
            n_fail++;
            $display("FAIL rmw_read: d_gnt=%b mem_w=%b mem_a=%h, want 1 0 0020", d_gnt, mem_w, mem_a);
        end
        step(); d_req = 0; i_req = 1; i_addr = 16'h0001;
        @(negedge clk);
        n_chk++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_w !== 1'b1 || mem_a !== 16'h0020 ||
            mem_d !== 32'hAA22CC44 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_write: gnt=%b%b mem_w=%b mem_a=%h mem_d=%h d_rvalid=%b, want 00 1 0020 aa22cc44 0",
                     i_gnt, d_gnt, mem_w, mem_a, mem_d, d_rvalid);
        end
        step();
        @(negedge clk);
        n_chk++;
        if (d_rvalid !== 1'b1 || d_rdata !== '0 || mem[16'h0020] !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL rmw_ack: d_rvalid=%b d_rdata=%h mem=%h, want 1 0 aa22cc44", d_rvalid, d_rdata, mem[16'h0020]);
        end
        i_req = 0;
        step(); step();
`else
        n_chk++;
        if (d_gnt !== 1'b1 || mem_w !== 1'b1 || mem_d !== 32'h11223344) begin
            n_fail++;
            $display("FAIL full_write: d_gnt=%b mem_w=%b mem_d=%h, want 1 1 11223344", d_gnt, mem_w, mem_d);
        end
        step(); d_req = 0;
        @(negedge clk);
        n_chk++;
        if (d_rvalid !== 1'b1 || d_rdata !== '0 || mem_w !== 1'b0 || mem[16'h0020] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL full_ack: d_rvalid=%b d_rdata=%h mem_w=%b mem=%h, want 1 0 0 11223344",
                     d_rvalid, d_rdata, mem_w, mem[16'h0020]);
        end
        step();
`endif
        d_be = 4'hF;
    endtask

`ifdef MEM_ARB_RMW_EN
    task automatic test_rst_rmw;
        preload(16'h0020, 32'hAABBCCDD);
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h11223344; d_be = 4'b0101;
        step(); d_req = 0; rst = 1;
        @(negedge clk);
        n_chk++;
        if (mem_w !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_write: mem_w=%b, want 0", mem_w);
        end
        step(); rst = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (d_rvalid !== 1'b0 || mem[16'h0020] !== 32'hAABBCCDD) begin
                n_fail++;
                $display("FAIL rst_rmw_abort[%0d]: d_rvalid=%b mem=%h, want 0 aabbccdd", k, d_rvalid, mem[16'h0020]);
            end
            step();
        end
        d_be = 4'hF;
    endtask
`endif

    // Reference: requests pend until granted; data wins unless four data grants
    // have already gone by with a fetch waiting; responses read a shadow memory.
    task automatic test_random;
        logic [`WORD-1:0] shadow [0:15];
        logic ip = 0, dp = 0, dwe = 0, gi, gd, ev_i = 0, ev_d = 0;
        logic [`ADDR-1:0] ia = '0, da = '0;
        logic [`WORD-1:0] wd = '0, er_i = '0, er_d = '0;
        int streak = 0;
        for (int a = 0; a < 16; a++) begin
            shadow[a] = $urandom;
            preload(16'(a), shadow[a]);
        end
        step();
        for (int c = 0; c < 400; c++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = 16'($urandom_range(0, 15)); end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); da = 16'($urandom_range(0, 15)); wd = $urandom;
            end
            i_req = ip; i_addr = ia; d_req = dp; d_we = dwe; d_addr = da; d_wdata = wd;
`ifdef MEM_ARB_RMW_EN
            d_be = 4'hF;
`else
            d_be = 4'($urandom);
`endif
            @(negedge clk);
            gi = ip && (!dp || streak >= 4);
            gd = dp && !gi;
            n_chk++;
            if (i_gnt !== gi || d_gnt !== gd || mem_w !== (gd && dwe)) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: i_gnt=%b d_gnt=%b mem_w=%b, want %b %b %b", c, i_gnt, d_gnt, mem_w, gi, gd, gd && dwe);
            end
            n_chk++;
            if (i_rvalid !== ev_i || i_rdata !== er_i || d_rvalid !== ev_d || d_rdata !== er_d) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: i=%b/%h d=%b/%h, want i=%b/%h d=%b/%h",
                         c, i_rvalid, i_rdata, d_rvalid, d_rdata, ev_i, er_i, ev_d, er_d);
            end
            ev_i = gi; er_i = gi ? shadow[ia[3:0]] : '0;
            ev_d = gd; er_d = (gd && !dwe) ? shadow[da[3:0]] : '0;
            if (gd && dwe) shadow[da[3:0]] = wd;
            streak = (!ip || gi) ? 0 : (gd && streak < 4) ? streak + 1 : streak;
            if (gi) ip = 0;
            if (gd) dp = 0;
            step();
        end
        i_req = 0; d_req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_starve();
        test_store_load();
        test_partial();
`ifdef MEM_ARB_RMW_EN
        test_rst_rmw();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
